// File: rtl/sweep_sequencer.sv
// Sweeps stimulus vectors through a combinational DUT, streams (vector, response)
// records over valid/ready and folds every captured response into a 32-bit MISR.
module sweep_sequencer #(
  parameter int unsigned IN_W       = 20,
  parameter int unsigned OUT_W      = 40,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [IN_W-1:0]  start_vec,
  input  logic [IN_W-1:0]  end_vec,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [IN_W-1:0]  rec_vec,
  output logic [OUT_W-1:0] rec_res,
  output logic [31:0]      signature,
  output logic [IN_W:0]    vec_count,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_EMIT,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IN_W-1:0]    end_q, end_d;
  logic [IN_W-1:0]    dut_in_q, dut_in_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               rec_valid_q, rec_valid_d;
  logic [IN_W-1:0]    rec_vec_q, rec_vec_d;
  logic [OUT_W-1:0]   rec_res_q, rec_res_d;
  logic [31:0]        sig_q, sig_d;
  logic [IN_W:0]      vcnt_q, vcnt_d;
  logic [63:0]        ext;
  logic [31:0]        fold;
  logic [31:0]        misr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      end_q       <= '0;
      dut_in_q    <= '0;
      cnt_q       <= '0;
      rec_valid_q <= 1'b0;
      rec_vec_q   <= '0;
      rec_res_q   <= '0;
      sig_q       <= '1;
      vcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      end_q       <= end_d;
      dut_in_q    <= dut_in_d;
      cnt_q       <= cnt_d;
      rec_valid_q <= rec_valid_d;
      rec_vec_q   <= rec_vec_d;
      rec_res_q   <= rec_res_d;
      sig_q       <= sig_d;
      vcnt_q      <= vcnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    end_d       = end_q;
    dut_in_d    = dut_in_q;
    cnt_d       = cnt_q;
    rec_valid_d = rec_valid_q;
    rec_vec_d   = rec_vec_q;
    rec_res_d   = rec_res_q;
    sig_d       = sig_q;
    vcnt_d      = vcnt_q;

    // Responses wider than 32 bits are folded onto the low word before shifting in.
    ext              = '0;
    ext[OUT_W-1:0]   = dut_out;
    fold             = ext[31:0] ^ ext[63:32];
    misr             = {sig_q[30:0], sig_q[31] ^ sig_q[21] ^ sig_q[1] ^ sig_q[0]} ^ fold;

    if (abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      rec_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            end_d  = end_vec;
            sig_d  = '1;
            vcnt_d = '0;
            if (end_vec < start_vec) begin
              state_d = S_DONE;
            end else begin
              dut_in_d = start_vec;
              cnt_d    = CW'(SETTLE_CYC - 1);
              state_d  = S_SETTLE;
            end
          end
        end
        S_SETTLE: begin
          if (cnt_q == '0) state_d = S_CAPTURE;
          else             cnt_d   = cnt_q - CW'(1);
        end
        S_CAPTURE: begin
          rec_vec_d   = dut_in_q;
          rec_res_d   = dut_out;
          rec_valid_d = 1'b1;
          sig_d       = misr;
          state_d     = S_EMIT;
        end
        S_EMIT: begin
          if (rec_ready) begin
            rec_valid_d = 1'b0;
            vcnt_d      = vcnt_q + (IN_W+1)'(1);
            // Equality test lets an all-ones end vector finish without wrapping.
            if (dut_in_q == end_q) begin
              state_d = S_DONE;
            end else begin
              dut_in_d = dut_in_q + IN_W'(1);
              cnt_d    = CW'(SETTLE_CYC - 1);
              state_d  = S_SETTLE;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign dut_in    = dut_in_q;
  assign rec_valid = rec_valid_q;
  assign rec_vec   = rec_vec_q;
  assign rec_res   = rec_res_q;
  assign signature = sig_q;
  assign vec_count = vcnt_q;
  assign busy      = (state_q == S_SETTLE) || (state_q == S_CAPTURE) || (state_q == S_EMIT);
  assign done      = (state_q == S_DONE);

endmodule

// File: doc/sweep_sequencer.md
Name: sweep_sequencer

Overview:
Controller that sequences exhaustive or ranged stimulus sweeps through the team's 20-in/40-out combinational DUT datapath. It drives one input vector at a time and waits a programmable settle time. It then captures the 40-bit response, streams each (vector, response) record to a log sink over a valid/ready handshake, and folds every response into a 32-bit MISR signature for fast equivalence comparison between netlists.

Parameters:
IN_W, 20, width of DUT input vector
OUT_W, 40, width of DUT response (must be 33..64)
SETTLE_CYC, 1, cycles dut_in is held stable before capture (>=1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins sweep, sampled only in IDLE
abort  input  1  terminates sweep; returns to IDLE without done
start_vec  input  IN_W  first vector, latched on accepted start
end_vec  input  IN_W  last vector (inclusive), latched on accepted start
dut_in  output  IN_W  vector driven to DUT
dut_out  input  OUT_W  DUT response
rec_valid  output  1  record available
rec_ready  input  1  sink accepts record
rec_vec  output  IN_W  vector of current record
rec_res  output  OUT_W  captured response of current record
signature  output  32  running MISR
vec_count  output  IN_W+1  records accepted by sink this sweep
busy  output  1  high in any state except IDLE/DONE
done  output  1  one-cycle pulse on sweep completion

Behaviour:
- Reset values: dut_in=0, rec_valid=0, rec_vec=0, rec_res=0, signature=32'hFFFF_FFFF, vec_count=0, busy=0, done=0, state=IDLE. Reset mid-sweep discards everything; no done.
- States: IDLE, SETTLE, CAPTURE, EMIT, DONE.
- IDLE: on start, latch bounds, set signature=32'hFFFF_FFFF, clear vec_count. If end_vec<start_vec -> DONE (zero records). Otherwise dut_in<=start_vec, settle counter<=SETTLE_CYC-1 -> SETTLE.
- SETTLE: hold dut_in; decrement counter; at 0 -> CAPTURE.
- CAPTURE (1 cycle): rec_vec<=dut_in, rec_res<=dut_out, rec_valid<=1, and update the MISR -> EMIT.
- MISR update:
  - fold = dut_out[31:0] ^ zero-extended dut_out[OUT_W-1:32].
  - sig_next = {sig[30:0], sig[31]^sig[21]^sig[1]^sig[0]} ^ fold.
- EMIT: rec_* held stable while rec_valid && !rec_ready.
  - On handshake: rec_valid<=0, vec_count+=1.
  - If dut_in==end_vec -> DONE.
  - Else dut_in+=1, reload settle counter -> SETTLE.
- End of sweep: the last vector is detected by equality, so all-ones end_vec terminates without wrap and a full 2^IN_W sweep is legal. vec_count is IN_W+1 bits so 2^IN_W fits.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. signature and vec_count hold until the next accepted start.
- Minimum latency: start to first rec_valid is 1+SETTLE_CYC+1 cycles. Per-record throughput with rec_ready tied high is SETTLE_CYC+2 cycles.
- start while busy is ignored.
- abort has priority over every other event in the same cycle.
  - Any non-IDLE state -> IDLE next edge.
  - rec_valid<=0, busy<=0, no done.
  - signature and vec_count keep their partial values.
- dut_in changes only on a state transition into SETTLE, never during SETTLE/CAPTURE/EMIT.

Test Plan:
1. Bench model dut_out={in,in}; start_vec=0, end_vec=3, SETTLE_CYC=1, rec_ready=1 -> 4 records (0..3) with rec_res={v,v}; vec_count=4; single done pulse; signature equals bench reference MISR.
2. start_vec=5, end_vec=2 -> done pulse 1 cycle after IDLE->DONE; zero rec_valid; vec_count=0; signature=32'hFFFF_FFFF.
3. Backpressure: rec_ready low 7 cycles during the record for vector 1 -> rec_vec/rec_res/rec_valid stable; dut_in stays 1; sequence resumes with vector 2 after the handshake.
4. IN_W=4 build, start_vec=4'hE, end_vec=4'hF -> records E, F, then done; no wrap to 0; vec_count=2. Full sweep 0..F -> vec_count=16.
5. abort asserted in the cycle a handshake occurs for vector 2 of sweep 0..9 -> IDLE next cycle, no done, busy=0, vec_count=2. A new start is then accepted normally.
6. rst pulsed asynchronously mid-SETTLE -> all outputs reach reset values before the next clk edge; start ignored while rst high.
